// File: rtl/fetch_pc_unit.sv
// Fetch-side PC owner: issues one-outstanding instruction fetches, applies execute
// redirects (JALR bit0 clearing, misalignment trap) and delivers instructions to decode.
module fetch_pc_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_target_i,
    input  logic            redirect_is_jalr_i,
    output logic            imem_req_valid_o,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_req_ready_i,
    input  logic            imem_rsp_valid_i,
    input  logic [XLEN-1:0] imem_rsp_data_i,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            misalign_exc_o
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALT
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic            kill;

    logic [XLEN-1:0] redirect_pc;
    logic            redirect_ok;
    logic            redirect_bad;
    logic            req_accept;

    function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] target,
                                                     input logic            is_jalr);
        return is_jalr ? {target[XLEN-1:1], 1'b0} : target;
    endfunction

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return |addr[1:0];
    endfunction

    assign redirect_pc  = align_target(redirect_target_i, redirect_is_jalr_i);
    assign redirect_ok  = redirect_valid_i && !is_misaligned(redirect_pc);
    assign redirect_bad = redirect_valid_i && is_misaligned(redirect_pc);

    // Request is gated by rst so nothing is offered to memory while reset is held.
    assign imem_req_valid_o = rst && (state == S_REQ);
    assign imem_req_addr_o  = pc;
    assign req_accept       = imem_req_valid_o && imem_req_ready_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_REQ;
            pc             <= RESET_PC;
            kill           <= 1'b0;
            instr_valid_o  <= 1'b0;
            instr_o        <= '0;
            pc_o           <= '0;
            pc_plus4_o     <= '0;
            misalign_exc_o <= 1'b0;
        end else begin
            misalign_exc_o <= redirect_bad;

            // Consumed instructions retire; any redirect flushes the wrong path.
            if ((instr_valid_o && !stall_i) || redirect_valid_i) begin
                instr_valid_o <= 1'b0;
            end

            case (state)
                S_REQ: begin
                    // A stale response landing here (after leaving HALT) settles the kill.
                    if (imem_rsp_valid_i) begin
                        kill <= 1'b0;
                    end
                    if (redirect_bad) begin
                        if (req_accept) begin
                            kill <= 1'b1;
                        end
                        state <= S_HALT;
                    end else if (redirect_ok) begin
                        pc <= redirect_pc;
                        if (req_accept) begin
                            kill  <= 1'b1;
                            state <= S_WAIT;
                        end
                    end else if (req_accept) begin
                        state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (imem_rsp_valid_i) begin
                        kill <= 1'b0;
                        if (redirect_bad) begin
                            state <= S_HALT;
                        end else if (redirect_ok) begin
                            pc    <= redirect_pc;
                            state <= S_REQ;
                        end else if (kill) begin
                            state <= S_REQ;
                        end else begin
                            instr_valid_o <= 1'b1;
                            instr_o       <= imem_rsp_data_i;
                            pc_o          <= pc;
                            pc_plus4_o    <= pc + XLEN'(4);
                            pc            <= pc + XLEN'(4);
                            state         <= stall_i ? S_HOLD : S_REQ;
                        end
                    end else if (redirect_bad) begin
                        kill  <= 1'b1;
                        state <= S_HALT;
                    end else if (redirect_ok) begin
                        kill <= 1'b1;
                        pc   <= redirect_pc;
                    end
                end

                S_HOLD: begin
                    if (redirect_bad) begin
                        state <= S_HALT;
                    end else if (redirect_ok) begin
                        pc    <= redirect_pc;
                        state <= S_REQ;
                    end else if (!stall_i) begin
                        state <= S_REQ;
                    end
                end

                S_HALT: begin
                    if (imem_rsp_valid_i) begin
                        kill <= 1'b0;
                    end
                    if (redirect_ok) begin
                        pc    <= redirect_pc;
                        state <= S_REQ;
                    end
                end

                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios followed by randomized traffic against
// a transaction-level model of the expected fetch stream.
module tb_fetch_pc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redir_v;
    logic [31:0] redir_t;
    logic        redir_j;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        ready;
    logic        rsp_v;
    logic [31:0] rsp_d;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] pc4_out;
    logic        exc;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // model state for the random phase
    logic [31:0] exp_pc, last_pc, last_instr, pend_addr, raw, t;
    logic        exp_valid, exp_exc, halted, pend, stale;
    logic        r_v, r_j, mis, give_rsp, spur, st, rdy, deliver;
    int          lat, stall_left;

    always #5 clk = ~clk;

    fetch_pc_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk                (clk),
        .rst                (rst),
        .stall_i            (stall),
        .redirect_valid_i   (redir_v),
        .redirect_target_i  (redir_t),
        .redirect_is_jalr_i (redir_j),
        .imem_req_valid_o   (req_valid),
        .imem_req_addr_o    (req_addr),
        .imem_req_ready_i   (ready),
        .imem_rsp_valid_i   (rsp_v),
        .imem_rsp_data_i    (rsp_d),
        .instr_valid_o      (instr_valid),
        .instr_o            (instr),
        .pc_o               (pc_out),
        .pc_plus4_o         (pc4_out),
        .misalign_exc_o     (exc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; redir_v = 1'b0; redir_t = '0; redir_j = 1'b0;
        ready = 1'b0; rsp_v = 1'b0; rsp_d = '0;
        step(); step();

        // reset state
        chk1("rst_req_valid", req_valid, 1'b0);
        chk1("rst_instr_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_pc4", pc4_out, 32'h0);
        chk1("rst_exc", exc, 1'b0);

        // first fetch after release
        rst = 1'b1; #1;
        chk1("t1_req_valid", req_valid, 1'b1);
        chk("t1_req_addr", req_addr, 32'h100);
        ready = 1'b1; step(); ready = 1'b0;
        chk1("t1_wait_no_req", req_valid, 1'b0);
        rsp_v = 1'b1; rsp_d = 32'h0000_0013; step(); rsp_v = 1'b0;
        chk1("t1_valid", instr_valid, 1'b1);
        chk("t1_instr", instr, 32'h0000_0013);
        chk("t1_pc", pc_out, 32'h100);
        chk("t1_pc4", pc4_out, 32'h104);
        chk1("t1_next_req", req_valid, 1'b1);
        chk("t1_next_addr", req_addr, 32'h104);

        // JALR redirect while requesting without ready
        redir_v = 1'b1; redir_t = 32'h0000_2005; redir_j = 1'b1; step();
        redir_v = 1'b0; redir_j = 1'b0;
        chk("t2_addr", req_addr, 32'h2004);
        chk1("t2_exc", exc, 1'b0);
        chk1("t2_req_valid", req_valid, 1'b1);
        chk1("t2_flush", instr_valid, 1'b0);

        // redirect in the cycle the request for 0x200 is accepted
        redir_v = 1'b1; redir_t = 32'h200; step(); redir_v = 1'b0;
        chk("t3_addr200", req_addr, 32'h200);
        redir_v = 1'b1; redir_t = 32'h3000; ready = 1'b1; step();
        redir_v = 1'b0; ready = 1'b0;
        chk1("t3_wait", req_valid, 1'b0);
        rsp_v = 1'b1; rsp_d = 32'hDEAD_BEEF; step(); rsp_v = 1'b0;
        chk1("t3_discard", instr_valid, 1'b0);
        chk1("t3_req_valid", req_valid, 1'b1);
        chk("t3_req_addr", req_addr, 32'h3000);
        ready = 1'b1; step(); ready = 1'b0;
        rsp_v = 1'b1; rsp_d = 32'h00A0_0093; step(); rsp_v = 1'b0;
        chk1("t3_valid", instr_valid, 1'b1);
        chk("t3_pc", pc_out, 32'h3000);
        chk("t3_instr", instr, 32'h00A0_0093);
        chk("t3_next_addr", req_addr, 32'h3004);

        // misaligned target traps and halts fetch
        redir_v = 1'b1; redir_t = 32'h0000_4002; step(); redir_v = 1'b0;
        chk1("t4_exc", exc, 1'b1);
        chk1("t4_halt_req", req_valid, 1'b0);
        chk1("t4_flush", instr_valid, 1'b0);
        step();
        chk1("t4_exc_pulse", exc, 1'b0);
        chk1("t4_halt_req2", req_valid, 1'b0);
        redir_v = 1'b1; redir_t = 32'h0000_5003; redir_j = 1'b1; step();
        redir_v = 1'b0; redir_j = 1'b0;
        chk1("t4_exc_again", exc, 1'b1);
        chk1("t4_halt_req3", req_valid, 1'b0);
        step();
        chk1("t4_exc_pulse2", exc, 1'b0);
        redir_v = 1'b1; redir_t = 32'h80; step(); redir_v = 1'b0;
        chk1("t4_resume", req_valid, 1'b1);
        chk("t4_resume_addr", req_addr, 32'h80);
        chk1("t4_exc_low", exc, 1'b0);

        // response arrives under a 3-cycle stall
        ready = 1'b1; step(); ready = 1'b0;
        rsp_v = 1'b1; rsp_d = 32'h1111_1111; stall = 1'b1; step(); rsp_v = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk1("t5_hold_valid", instr_valid, 1'b1);
            chk("t5_hold_instr", instr, 32'h1111_1111);
            chk("t5_hold_pc", pc_out, 32'h80);
            chk1("t5_hold_no_req", req_valid, 1'b0);
            if (k == 2) stall = 1'b0;
            step();
        end
        chk1("t5_req_after", req_valid, 1'b1);
        chk("t5_req_addr", req_addr, 32'h84);
        chk1("t5_consumed", instr_valid, 1'b0);

        // pc wrap-around
        redir_v = 1'b1; redir_t = 32'hFFFF_FFFC; step(); redir_v = 1'b0;
        chk("t7_addr", req_addr, 32'hFFFF_FFFC);
        ready = 1'b1; step(); ready = 1'b0;
        rsp_v = 1'b1; rsp_d = 32'h0000_006F; step(); rsp_v = 1'b0;
        chk("t7_pc", pc_out, 32'hFFFF_FFFC);
        chk("t7_pc4", pc4_out, 32'h0);
        chk("t7_next_addr", req_addr, 32'h0);
        chk1("t7_exc", exc, 1'b0);

        // async reset with a request outstanding
        ready = 1'b1; step(); ready = 1'b0;
        chk1("t6_wait", req_valid, 1'b0);
        #2 rst = 1'b0; #1;
        chk1("t6_valid", instr_valid, 1'b0);
        chk("t6_instr", instr, 32'h0);
        chk("t6_pc", pc_out, 32'h0);
        chk("t6_pc4", pc4_out, 32'h0);
        chk1("t6_req_valid", req_valid, 1'b0);
        chk("t6_addr", req_addr, 32'h100);
        step();
        rst = 1'b1; #1;
        chk1("t6_restart", req_valid, 1'b1);
        chk("t6_restart_addr", req_addr, 32'h100);
        ready = 1'b1; step(); ready = 1'b0;
        rsp_v = 1'b1; rsp_d = 32'h0000_0013; step(); rsp_v = 1'b0;
        chk1("t6_valid2", instr_valid, 1'b1);
        chk("t6_pc2", pc_out, 32'h100);

        // randomized traffic against the fetch-stream model
        rst = 1'b0; step(); rst = 1'b1; #1;
        exp_pc = RST_PC; exp_valid = 1'b0; exp_exc = 1'b0; halted = 1'b0;
        pend = 1'b0; stale = 1'b0; lat = 0; stall_left = 0;
        last_pc = '0; last_instr = '0; pend_addr = '0;
        for (int i = 0; i < 4000; i++) begin
            chk1("rnd_valid", instr_valid, exp_valid);
            if (exp_valid) begin
                chk("rnd_pc", pc_out, last_pc);
                chk("rnd_instr", instr, last_instr);
                chk("rnd_pc4", pc4_out, last_pc + 32'd4);
            end
            chk1("rnd_exc", exc, exp_exc);
            if (halted) chk1("rnd_halt_req", req_valid, 1'b0);
            else if (req_valid) chk("rnd_addr", req_addr, exp_pc);

            r_v = halted ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            r_j = 1'($urandom_range(0, 1));
            raw = $urandom;
            if ($urandom_range(0, 3) == 0) raw[31:4] = '1;
            if ($urandom_range(0, 4) != 0) raw[1:0] = r_j ? {1'b0, raw[0]} : 2'b00;
            t   = r_j ? {raw[31:1], 1'b0} : raw;
            mis = |t[1:0];

            give_rsp = pend && (lat == 0);
            spur     = !pend && (req_valid || halted) && ($urandom_range(0, 15) == 0);
            if (stall_left > 0) begin
                st = 1'b1; stall_left--;
            end else if (give_rsp && $urandom_range(0, 2) == 0) begin
                st = 1'b1; stall_left = $urandom_range(0, 3);
            end else begin
                st = 1'b0;
            end
            rdy     = !pend && !(exp_valid && st) && ($urandom_range(0, 1) == 1);
            deliver = give_rsp && !stale && !r_v;

            if (r_v) exp_valid = 1'b0;
            else if (deliver) begin
                exp_valid  = 1'b1;
                last_pc    = exp_pc;
                last_instr = mem_word(exp_pc);
                exp_pc     = exp_pc + 32'd4;
            end else if (exp_valid && !st) exp_valid = 1'b0;
            exp_exc = r_v && mis;
            if (r_v) begin
                if (mis) halted = 1'b1;
                else begin halted = 1'b0; exp_pc = t; end
            end

            redir_v = r_v; redir_j = r_j; redir_t = raw;
            rsp_v   = give_rsp || spur;
            rsp_d   = give_rsp ? mem_word(pend_addr) : $urandom;
            stall   = st;
            ready   = rdy;

            if (give_rsp) pend = 1'b0;
            else if (pend) lat--;
            if (pend && r_v) stale = 1'b1;
            if (req_valid && rdy) begin
                pend = 1'b1; pend_addr = req_addr; lat = $urandom_range(0, 2); stale = r_v;
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Fetch-side consumer of the execute-stage branch/jump target adder.
- Owns the architectural PC register and issues one-outstanding-request fetches to instruction memory over a valid/ready interface.
- Applies redirects from execute: JALR targets arrive with bit0 not yet cleared and are aligned here; misaligned targets are trapped.
- Delivers fetched instructions, with their PC and PC+4, to the decode pipeline register, honouring hazard stalls.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- XLEN, 32, address/data width (only 32 is supported).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous active-low reset (rst==0 resets).
- stall_i  in  1  decode hazard stall; holds the delivered instruction.
- redirect_valid_i  in  1  one-cycle redirect strobe from execute.
- redirect_target_i  in  32  computed branch/jump target.
- redirect_is_jalr_i  in  1  1 means clear bit0 of target before use.
- imem_req_valid_o  out  1  fetch request valid.
- imem_req_addr_o  out  32  fetch address; always word aligned.
- imem_req_ready_i  in  1  memory accepts request this cycle.
- imem_rsp_valid_i  in  1  response data valid; exactly one per accepted request.
- imem_rsp_data_i  in  32  instruction word.
- instr_valid_o  out  1  instr_o/pc_o/pc_plus4_o are valid.
- instr_o  out  32  instruction to decode.
- pc_o  out  32  PC of instr_o.
- pc_plus4_o  out  32  pc_o+4, mod 2^32.
- misalign_exc_o  out  1  one-cycle pulse when a redirect target is misaligned.

Behaviour:
- Reset (async, rst low):
  - pc = RESET_PC; state = REQ; kill = 0.
  - instr_valid_o = 0, instr_o = 0, pc_o = 0, pc_plus4_o = 0, misalign_exc_o = 0.
  - imem_req_valid_o = 0 while rst is low. It asserts in the first cycle after rst deasserts.
- States: REQ, WAIT, HOLD, HALT. All outputs are registered except imem_req_valid_o and imem_req_addr_o, which decode state (REQ -> 1) and the pc register.
- Redirect alignment:
  - t = redirect_is_jalr_i ? {target[31:1],1'b0} : target.
  - If t[1:0] != 0: pulse misalign_exc_o, leave pc unchanged, go to HALT, drop any in-flight response. While in HALT, imem_req_valid_o = 0.
  - Otherwise pc <= t.
- Redirect priority: a redirect overrides stall_i and the sequential pc+4 in the same cycle.
- Redirect latency: redirect in cycle N -> imem_req_addr_o == t in cycle N+1.
- Redirect side effects: instr_valid_o is cleared in cycle N+1, which flushes the wrong-path instruction.
- REQ: imem_req_valid_o = 1, addr = pc.
  - On imem_req_ready_i -> WAIT.
  - Redirect without ready: pc updates and the request address changes next cycle. Withdrawing an unaccepted request is permitted.
  - Redirect with ready in the same cycle: the request is accepted but stale. Set kill = 1, update pc, go to WAIT.
- WAIT: imem_req_valid_o = 0. On imem_rsp_valid_i:
  - kill = 1: discard data, clear kill -> REQ.
  - Redirect in the same cycle: discard -> REQ.
  - Otherwise: instr_o <= data, pc_o <= pc, pc_plus4_o <= pc+4, instr_valid_o <= 1, pc <= pc+4.
    - stall_i = 0 -> REQ.
    - stall_i = 1 -> HOLD.
  - Redirect while waiting with no response: set kill, update pc, stay in WAIT.
- Data transfer: an instruction is consumed by decode in any cycle with instr_valid_o = 1 and stall_i = 0. instr_valid_o falls the cycle after consumption unless a new instruction is delivered.
- HOLD: instr_valid_o, instr_o and pc_o are held stable while stall_i = 1.
  - stall_i = 0 -> REQ.
  - Redirect -> clear instr_valid_o, update pc -> REQ.
- HALT: leave only on a valid aligned redirect -> REQ with the new pc. A misaligned redirect in HALT re-pulses misalign_exc_o.
- Wrap-around: pc = 32'hFFFF_FFFC advances to 0. No exception is raised.
- Throughput: a steady-state fetch with 0-wait memory takes 2 cycles per instruction (REQ, WAIT). There is never more than one outstanding request.
- An unexpected imem_rsp_valid_i in REQ or HALT is ignored.

Test Plan:
- Reset release, RESET_PC=0x100, ready=1, rsp one cycle later with 0x00000013 -> first request addr 0x100; instr_valid_o=1, pc_o=0x100, pc_plus4_o=0x104; next request addr 0x104.
- JALR redirect, target 0x00002005, is_jalr=1 while in REQ without ready -> next cycle imem_req_addr_o=0x2004, misalign_exc_o=0; the 0x2005 value never appears on imem_req_addr_o.
- Branch redirect to 0x3000 in the cycle the request for 0x200 is accepted -> the response for 0x200 is discarded (instr_valid_o stays 0); the next request is 0x3000, and pc_o=0x3000 on delivery.
- Misaligned target 0x00004002 (is_jalr=0) -> misalign_exc_o high exactly 1 cycle; imem_req_valid_o=0 until a redirect to 0x80 arrives, then the request addr is 0x80.
- Response arrives with stall_i held for 3 cycles -> instr_valid_o/instr_o/pc_o constant for 3 cycles, no new request issued; the request for pc+4 is issued the cycle after stall_i drops.
- Async reset asserted mid-WAIT (outstanding request) -> outputs zero immediately; after release, fetch restarts at RESET_PC.
